// File: rtl/ntt_net_pkg.sv
// Shared constants for the NTT butterfly in/out crossbars: default widths, bank count, source select codes.
package ntt_net_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_LAT    = 4;
  localparam int NBANK      = 4;
  localparam int SEL_W      = 2;

  localparam logic [SEL_W-1:0] SEL_X0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_Y0 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_X1 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_Y1 = 2'd3;
endpackage

// File: rtl/network_delay_line.sv
// Fixed-depth shift register, cleared by async reset; latency DEPTH cycles, no stall (shifts every cycle).
module network_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];
endmodule

// File: rtl/network_bf_out.sv
// Butterfly write-back crossbar: delays issue tags by LAT, muxes x0/y0/x1/y1 onto four bank write ports.
// Latency LAT+1 issue->write, no backpressure. Optional checker under NETWORK_BF_OUT_CHECK_EN.
module network_bf_out
  import ntt_net_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic [SEL_W-1:0]  sel_b_0,
  input  logic [SEL_W-1:0]  sel_b_1,
  input  logic [SEL_W-1:0]  sel_b_2,
  input  logic [SEL_W-1:0]  sel_b_3,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [ADDR_W-1:0] addr_3,
  input  logic              bf_vld,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic [ADDR_W-1:0] wa0,
  output logic [ADDR_W-1:0] wa1,
  output logic [ADDR_W-1:0] wa2,
  output logic [ADDR_W-1:0] wa3,
  output logic              we0,
  output logic              we1,
  output logic              we2,
  output logic              we3,
  output logic              busy,
  output logic              drain,
  output logic              err
);
  localparam int TAG_W = 1 + NBANK*SEL_W + NBANK*ADDR_W;

  logic [TAG_W-1:0]  tag_in, tag_out;
  logic              tag_vld;
  logic [SEL_W-1:0]  tag_sel  [NBANK];
  logic [ADDR_W-1:0] tag_addr [NBANK];

  assign tag_in = {issue_vld, sel_b_0, sel_b_1, sel_b_2, sel_b_3, addr_0, addr_1, addr_2, addr_3};

  network_delay_line #(.WIDTH(TAG_W), .DEPTH(LAT)) u_tag_dl (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign {tag_vld, tag_sel[0], tag_sel[1], tag_sel[2], tag_sel[3],
          tag_addr[0], tag_addr[1], tag_addr[2], tag_addr[3]} = tag_out;

  logic [DATA_W-1:0] mux_dat [NBANK];

  always_comb begin
    for (int k = 0; k < NBANK; k++) begin
      mux_dat[k] = x0;
      case (tag_sel[k])
        SEL_Y0:  mux_dat[k] = y0;
        SEL_X1:  mux_dat[k] = x1;
        SEL_Y1:  mux_dat[k] = y1;
        default: mux_dat[k] = x0;
      endcase
    end
  end

  logic [DATA_W-1:0] d_q  [NBANK];
  logic [ADDR_W-1:0] wa_q [NBANK];
  logic [NBANK-1:0]  we_q;

  // Data/address only load on a valid tag so idle cycles leave the bank buses quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q <= '0;
      for (int k = 0; k < NBANK; k++) begin
        d_q[k]  <= '0;
        wa_q[k] <= '0;
      end
    end else begin
      we_q <= {NBANK{tag_vld}};
      if (tag_vld) begin
        for (int k = 0; k < NBANK; k++) begin
          d_q[k]  <= mux_dat[k];
          wa_q[k] <= tag_addr[k];
        end
      end
    end
  end

  assign {d0, d1, d2, d3}     = {d_q[0], d_q[1], d_q[2], d_q[3]};
  assign {wa0, wa1, wa2, wa3} = {wa_q[0], wa_q[1], wa_q[2], wa_q[3]};
  assign {we3, we2, we1, we0} = we_q;

  logic [3:0] inflight;
  logic [4:0] inflight_sum;
  logic       busy_q;

  assign inflight_sum = {1'b0, inflight} + {4'b0, issue_vld} - {4'b0, tag_vld};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      busy_q   <= 1'b0;
    end else begin
      inflight <= inflight_sum[3:0];
      busy_q   <= busy;
    end
  end

  assign busy  = (inflight != 4'd0) | (|we_q);
  assign drain = busy_q & ~busy;

`ifdef NETWORK_BF_OUT_CHECK_EN
  logic [SEL_W-1:0] iss_sel [NBANK];
  logic             dup_sel, vld_mis, over;
  logic             err_q;

  assign iss_sel = '{sel_b_0, sel_b_1, sel_b_2, sel_b_3};

  always_comb begin
    dup_sel = 1'b0;
    for (int i = 0; i < NBANK; i++)
      for (int j = i + 1; j < NBANK; j++)
        if (iss_sel[i] == iss_sel[j]) dup_sel = 1'b1;
    dup_sel = dup_sel & issue_vld;
  end

  assign vld_mis = tag_vld != bf_vld;
  assign over    = inflight_sum > 5'(LAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | dup_sel | vld_mis | over;
  end

  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = bf_vld ^ inflight_sum[4];
  assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_network_bf_out.sv
// Directed bench for network_bf_out: LAT=4 main instance plus a LAT=1 instance for the short-latency case.
module tb_network_bf_out;
`ifdef NETWORK_BF_OUT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_vld, bf_vld;
  logic [1:0]  sel_b_0, sel_b_1, sel_b_2, sel_b_3;
  logic [6:0]  addr_0, addr_1, addr_2, addr_3;
  logic [11:0] x0, y0, x1, y1;

  logic [11:0] d0, d1, d2, d3;
  logic [6:0]  wa0, wa1, wa2, wa3;
  logic        we0, we1, we2, we3, busy, drain, err;
  logic [11:0] e_d0, e_d1, e_d2, e_d3;
  logic [6:0]  e_wa0, e_wa1, e_wa2, e_wa3;
  logic        e_we0, e_we1, e_we2, e_we3, e_busy, e_drain, e_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  network_bf_out #(.DATA_W(12), .ADDR_W(7), .LAT(4)) u_dut (
    .clk(clk), .rst(rst), .issue_vld(issue_vld),
    .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
    .bf_vld(bf_vld), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3),
    .we0(we0), .we1(we1), .we2(we2), .we3(we3), .busy(busy), .drain(drain), .err(err)
  );

  network_bf_out #(.DATA_W(12), .ADDR_W(7), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .issue_vld(issue_vld),
    .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
    .bf_vld(bf_vld), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .d0(e_d0), .d1(e_d1), .d2(e_d2), .d3(e_d3), .wa0(e_wa0), .wa1(e_wa1), .wa2(e_wa2), .wa3(e_wa3),
    .we0(e_we0), .we1(e_we1), .we2(e_we2), .we3(e_we3), .busy(e_busy), .drain(e_drain), .err(e_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [1:0] s0, s1, s2, s3, input logic [6:0] a0, a1, a2, a3);
    issue_vld = 1'b1;
    {sel_b_0, sel_b_1, sel_b_2, sel_b_3} = {s0, s1, s2, s3};
    {addr_0, addr_1, addr_2, addr_3}     = {a0, a1, a2, a3};
  endtask

  task automatic set_data(input logic [11:0] v0, v1, v2, v3, input logic bv);
    {x0, y0, x1, y1} = {v0, v1, v2, v3};
    bf_vld = bv;
  endtask

  function automatic logic [3:0] we_vec();
    return {we3, we2, we1, we0};
  endfunction

  function automatic logic [11:0] d_of(input int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [6:0] wa_of(input int k);
    case (k)
      0: return wa0;
      1: return wa1;
      2: return wa2;
      default: return wa3;
    endcase
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with live inputs
    rst = 1'b0;
    set_issue(2'd0, 2'd1, 2'd2, 2'd3, 7'd9, 7'd9, 7'd9, 7'd9);
    set_data(12'd7, 12'd7, 12'd7, 12'd7, 1'b1);
    repeat (3) step();
    chk("rst_d0", 32'(d0), 32'd0);
    chk("rst_wa3", 32'(wa3), 32'd0);
    chk("rst_we", 32'(we_vec()), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drain", 32'(drain), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    issue_vld = 1'b0;
    set_data(12'd0, 12'd0, 12'd0, 12'd0, 1'b0);
    repeat (10) step();
    chk("rel_we", 32'(we_vec()), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // 2: single issue, write at t+5, drain at t+6
    set_issue(2'd0, 2'd1, 2'd2, 2'd3, 7'd5, 7'd6, 7'd7, 7'd8);
    step();
    issue_vld = 1'b0;
    chk("s_busy1", 32'(busy), 32'd1);
    step(); step();
    chk("s_we3", 32'(we_vec()), 32'd0);
    step();
    set_data(12'd1, 12'd2, 12'd3, 12'd4, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("s_d", 32'(d_of(k)), 32'(k + 1));
      chk("s_wa", 32'(wa_of(k)), 32'(k + 5));
    end
    chk("s_we5", 32'(we_vec()), 32'hf);
    chk("s_busy5", 32'(busy), 32'd1);
    chk("s_drain5", 32'(drain), 32'd0);
    set_data(12'd9, 12'd9, 12'd9, 12'd9, 1'b0);
    step();
    chk("s_we6", 32'(we_vec()), 32'd0);
    chk("s_drain6", 32'(drain), 32'd1);
    chk("s_busy6", 32'(busy), 32'd0);
    chk("s_hold_d2", 32'(d2), 32'd3);
    step();
    chk("s_drain7", 32'(drain), 32'd0);

    // 3: burst of 8 with rotating selects; bank k reads source (k+i)%4, source s carries (s+1)*100+i
    for (int c = 0; c < 15; c++) begin
      if (c >= 5 && c <= 12) begin
        for (int k = 0; k < 4; k++) begin
          chk("b_d", 32'(d_of(k)), 32'((((k + c - 5) % 4) + 1) * 100 + (c - 5)));
          chk("b_wa", 32'(wa_of(k)), 32'(10 * (c - 5) + k));
        end
        chk("b_we", 32'(we_vec()), 32'hf);
      end else begin
        chk("b_we_idle", 32'(we_vec()), 32'd0);
      end
      chk("b_busy", 32'(busy), 32'((c >= 1 && c <= 12) ? 1 : 0));
      chk("b_drain", 32'(drain), 32'((c == 13) ? 1 : 0));
      chk("b_cnt_le4", 32'(u_dut.inflight <= 4'd4), 32'd1);
      if (c < 8)
        set_issue(2'((0 + c) % 4), 2'((1 + c) % 4), 2'((2 + c) % 4), 2'((3 + c) % 4),
                  7'(10 * c), 7'(10 * c + 1), 7'(10 * c + 2), 7'(10 * c + 3));
      else
        issue_vld = 1'b0;
      if (c >= 4 && c <= 11)
        set_data(12'(100 + c - 4), 12'(200 + c - 4), 12'(300 + c - 4), 12'(400 + c - 4), 1'b1);
      else
        set_data(12'd0, 12'd0, 12'd0, 12'd0, 1'b0);
      step();
    end
    chk("b_err_clean", 32'(err), 32'd0);

    // 4: reset in the middle of a burst
    set_issue(2'd0, 2'd1, 2'd2, 2'd3, 7'd1, 7'd2, 7'd3, 7'd4);
    step(); step();
    rst = 1'b0;
    step();
    chk("m_we_rst", 32'(we_vec()), 32'd0);
    chk("m_busy_rst", 32'(busy), 32'd0);
    rst = 1'b1;
    issue_vld = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("m_we", 32'(we_vec()), 32'd0);
      chk("m_busy", 32'(busy), 32'd0);
    end
    chk("m_err", 32'(err), 32'd0);

    // 5: checker -- duplicated source, then missing bf_vld on a clean issue
    set_issue(2'd1, 2'd0, 2'd1, 2'd3, 7'd0, 7'd1, 7'd2, 7'd3);
    step();
    issue_vld = 1'b0;
    chk("c_dup_err", 32'(err), 32'(CHK));
    repeat (3) step();
    chk("c_dup_hold", 32'(err), 32'(CHK));
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    set_issue(2'd0, 2'd1, 2'd2, 2'd3, 7'd0, 7'd1, 7'd2, 7'd3);
    step();
    issue_vld = 1'b0;
    repeat (3) step();
    chk("c_pre_err", 32'(err), 32'd0);
    step();
    chk("c_vld_err", 32'(err), 32'(CHK));
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // 6: LAT=1 instance -- 3 back-to-back issues, data one cycle later, writes two cycles later
    for (int c = 0; c < 7; c++) begin
      chk("l1_we", 32'({e_we3, e_we2, e_we1, e_we0}), 32'((c >= 2 && c <= 4) ? 4'hf : 4'h0));
      if (c >= 2 && c <= 4) begin
        chk("l1_d0", 32'(e_d0), 32'(10 + c - 1));
        chk("l1_d3", 32'(e_d3), 32'(40 + c - 1));
        chk("l1_wa1", 32'(e_wa1), 32'(20 + c - 2));
      end
      if (c >= 1 && c <= 4)
        chk("l1_cnt", 32'(u_lat1.inflight), 32'((c <= 3) ? 1 : 0));
      if (c <= 2)
        set_issue(2'd0, 2'd1, 2'd2, 2'd3, 7'(10 + c), 7'(20 + c), 7'(30 + c), 7'(40 + c));
      else
        issue_vld = 1'b0;
      if (c >= 1 && c <= 3)
        set_data(12'(10 + c), 12'(20 + c), 12'(30 + c), 12'(40 + c), 1'b1);
      else
        set_data(12'd0, 12'd0, 12'd0, 12'd0, 1'b0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
